// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for an external combinational mul/div unit.
// Holds the operands steady for a fixed latency, then commits the result into HI/LO.
module md_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] dmu_a,
  output logic [WIDTH-1:0] dmu_b,
  output logic [3:0]       dmu_m,
  output logic             dmu_en,
  input  logic [WIDTH-1:0] dmu_hi,
  input  logic [WIDTH-1:0] dmu_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             bad_op
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [3:0]       op_q, op_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] hi_q, hi_nxt;
  logic [WIDTH-1:0] lo_q, lo_nxt;
  logic             done_q, done_nxt;
  logic             dz_q, dz_nxt;
  logic             bad_q, bad_nxt;
  logic             op_legal;

  // Legal ops are exactly {x00x}: bit 3 selects signedness, bit 0 selects divide.
  assign op_legal = (req_op[2:1] == 2'b00);

  assign req_ready = (state == IDLE);
  assign busy      = (state == EXEC);
  assign dmu_en    = (state == EXEC);
  assign dmu_a     = a_q;
  assign dmu_b     = b_q;
  assign dmu_m     = op_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign bad_op    = bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    done_nxt  = 1'b0;
    dz_nxt    = 1'b0;
    bad_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        // Move-to writes land first; an op accepted on the same edge overwrites them later.
        if (mthi) hi_nxt = mt_data;
        if (mtlo) lo_nxt = mt_data;
        if (req_valid) begin
          op_nxt = req_op;
          a_nxt  = req_a;
          b_nxt  = req_b;
          if (op_legal) begin
            state_nxt = EXEC;
            cnt_nxt   = req_op[0] ? DIV_CNT : MUL_CNT;
          end else begin
            done_nxt = 1'b1;
            bad_nxt  = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          // A zero divisor leaves HI/LO holding their previous contents.
          if (op_q[0] && (b_q == '0)) begin
            dz_nxt = 1'b1;
          end else begin
            hi_nxt = dmu_hi;
            lo_nxt = dmu_lo;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 4'd0;
      op_q   <= 4'd0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      op_q   <= op_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      done_q <= done_nxt;
      dz_q   <= dz_nxt;
      bad_q  <= bad_nxt;
    end
  end

endmodule
